// File: rtl/boy_lcd_pkg.sv
// Shared types and geometry helpers for the boy LCD capture path.
package boy_lcd_pkg;

  typedef enum logic [0:0] {
    WAIT_VS = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Words per line and per frame for a given geometry.
  function automatic int calc_wpl(input int h_pixels, input int pack);
    return ceil_div(h_pixels, pack);
  endfunction

  function automatic int calc_frame_words(input int h_pixels, input int v_lines, input int pack);
    return v_lines * ceil_div(h_pixels, pack);
  endfunction

endpackage

// File: rtl/lcd_wr_fifo.sv
// Two-entry write queue between the pixel packer and the framebuffer port.
module lcd_wr_fifo #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/boy_lcd_capture.sv
// LCD capture engine: turns the core's pixel/sync strobes into packed,
// linearly addressed framebuffer writes with optional ping-pong buffering.
module boy_lcd_capture
  import boy_lcd_pkg::*;
#(
  parameter int H_PIXELS   = 160,
  parameter int V_LINES    = 144,
  parameter int PIX_BITS   = 2,
  parameter int PACK       = 4,
  parameter int DOUBLE_BUF = 1,
  parameter int ADDR_W     = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cpl,
  input  logic                     hs,
  input  logic                     vs,
  input  logic                     valid,
  input  logic [PIX_BITS-1:0]      pixel,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [PACK*PIX_BITS-1:0] wr_data,
  output logic                     front_buf,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int WORD_W      = PACK * PIX_BITS;
  localparam int WPL         = calc_wpl(H_PIXELS, PACK);
  localparam int FRAME_WORDS = calc_frame_words(H_PIXELS, V_LINES, PACK);
  localparam int X_W         = $clog2(H_PIXELS + 1);
  localparam int Y_W         = $clog2(V_LINES + 1);
  localparam int SLOT_W      = (PACK > 1) ? $clog2(PACK) : 1;

  cap_state_t          state;
  logic                cpl_q, cpl_p, hs_q, hs_p, vs_q, vs_p, valid_q;
  logic [PIX_BITS-1:0] pix_q;
  logic [X_W-1:0]      x, x_tk;
  logic [Y_W-1:0]      y;
  logic [SLOT_W-1:0]   slot;
  logic [WORD_W-1:0]   pack_reg, pack_tk;
  logic [ADDR_W-1:0]   word_addr, line_base, cur_base, next_base;
  logic                back_buf;
  logic                pend_vld;
  logic [ADDR_W-1:0]   pend_addr;
  logic [WORD_W-1:0]   pend_data;
  logic                frame_pending;
  logic                cpl_rise, hs_rise, vs_rise;
  logic                take, word_full, has_partial, emit;
  logic                fifo_full, fifo_empty;
  logic [ADDR_W+WORD_W-1:0] fifo_out;

  assign cpl_rise  = cpl_q & ~cpl_p;
  assign hs_rise   = hs_q & ~hs_p;
  assign vs_rise   = vs_q & ~vs_p;
  assign cur_base  = (DOUBLE_BUF != 0 && back_buf) ? ADDR_W'(FRAME_WORDS) : '0;
  assign next_base = (DOUBLE_BUF != 0 && !back_buf) ? ADDR_W'(FRAME_WORDS) : '0;

  // The pixel of this cycle is merged first so a coincident hs/vs flushes it.
  always_comb begin
    take = (state == CAPTURE) && cpl_rise && valid_q &&
           (x < X_W'(H_PIXELS)) && (y < Y_W'(V_LINES));
    pack_tk = pack_reg;
    for (int i = 0; i < PACK; i++) begin
      if (take && (slot == SLOT_W'(i))) begin
        pack_tk[i*PIX_BITS +: PIX_BITS] = pix_q;
      end
    end
    word_full   = take && (slot == SLOT_W'(PACK - 1));
    has_partial = (take || (slot != '0)) && !word_full;
    emit        = word_full || ((state == CAPTURE) && (hs_rise || vs_rise) && has_partial);
    x_tk        = x + X_W'(take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_VS;
      cpl_q         <= 1'b0;
      cpl_p         <= 1'b0;
      hs_q          <= 1'b0;
      hs_p          <= 1'b0;
      vs_q          <= 1'b0;
      vs_p          <= 1'b0;
      valid_q       <= 1'b0;
      pix_q         <= '0;
      x             <= '0;
      y             <= '0;
      slot          <= '0;
      pack_reg      <= '0;
      word_addr     <= '0;
      line_base     <= '0;
      back_buf      <= 1'b0;
      front_buf     <= 1'b0;
      pend_vld      <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
      frame_pending <= 1'b0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      cpl_q   <= cpl;
      cpl_p   <= cpl_q;
      hs_q    <= hs;
      hs_p    <= hs_q;
      vs_q    <= vs;
      vs_p    <= vs_q;
      valid_q <= valid;
      pix_q   <= pixel;

      frame_done <= 1'b0;
      if (frame_pending && fifo_empty && !pend_vld) begin
        frame_done    <= 1'b1;
        frame_pending <= 1'b0;
      end

      pend_vld <= 1'b0;
      if (pend_vld && fifo_full) begin
        overflow <= 1'b1;
      end

      case (state)
        WAIT_VS: begin
          if (vs_rise && enable) begin
            state     <= CAPTURE;
            x         <= '0;
            y         <= '0;
            slot      <= '0;
            pack_reg  <= '0;
            word_addr <= cur_base;
            line_base <= cur_base;
          end
        end

        CAPTURE: begin
          x <= x_tk;
          if (emit) begin
            pend_vld  <= 1'b1;
            pend_addr <= word_addr;
            pend_data <= pack_tk;
            pack_reg  <= '0;
            slot      <= '0;
            word_addr <= word_addr + 1'b1;
          end else if (take) begin
            pack_reg <= pack_tk;
            slot     <= slot + 1'b1;
          end

          // vs dominates hs; the address counter reloads to the new buffer base.
          if (vs_rise) begin
            if (x_tk != '0 || y != '0) begin
              frame_pending <= 1'b1;
            end
            if (DOUBLE_BUF != 0) begin
              back_buf  <= ~back_buf;
              front_buf <= back_buf;
            end
            x         <= '0;
            y         <= '0;
            slot      <= '0;
            pack_reg  <= '0;
            word_addr <= next_base;
            line_base <= next_base;
            if (!enable) begin
              state <= WAIT_VS;
            end
          end else if (hs_rise) begin
            x        <= '0;
            slot     <= '0;
            pack_reg <= '0;
            if (y < Y_W'(V_LINES)) begin
              y         <= y + 1'b1;
              line_base <= line_base + ADDR_W'(WPL);
              word_addr <= line_base + ADDR_W'(WPL);
            end
          end
        end

        default: state <= WAIT_VS;
      endcase
    end
  end

  lcd_wr_fifo #(
    .WIDTH(ADDR_W + WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pend_vld),
    .push_data({pend_addr, pend_data}),
    .pop      (wr_valid && wr_ready),
    .pop_data (fifo_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wr_valid = !fifo_empty;
  assign wr_addr  = fifo_out[ADDR_W+WORD_W-1:WORD_W];
  assign wr_data  = fifo_out[WORD_W-1:0];

endmodule

// File: tb/tb_boy_lcd_capture.sv
// Directed bench for boy_lcd_capture: drives LCD strobe sequences and checks
// every framebuffer write against a frame/line/pixel model of the capture rules.
module tb_boy_lcd_capture;

  localparam int H   = 160;
  localparam int V   = 144;
  localparam int PB  = 2;
  localparam int PK  = 4;
  localparam int AW  = 14;
  localparam int WPL = 40;
  localparam int FW  = 5760;
  localparam int EW  = AW + PK * PB;

  logic clk = 1'b0;
  logic rst, enable, cpl, hs, vs, valid, wr_ready;
  logic [PB-1:0]    pixel;
  logic             wr_valid, front_buf, frame_done, overflow;
  logic [AW-1:0]    wr_addr;
  logic [PK*PB-1:0] wr_data;

  int vec_count  = 0;
  int err_count  = 0;
  int dut_frames = 0;
  int exp_frames = 0;

  // Model state: expected writes still owed by the DUT, and the log of accepted writes.
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    acc_log[$];
  int               m_x, m_y, m_back, m_front, m_fill, m_word_addr;
  bit               m_cap, exp_ovf;
  logic [PK*PB-1:0] m_word;

  always #5 clk = ~clk;

  boy_lcd_capture dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cpl       (cpl),
    .hs        (hs),
    .vs        (vs),
    .valid     (valid),
    .pixel     (pixel),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .front_buf (front_buf),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cap   = 1'b0;
    m_back  = 0;
    m_front = 0;
    m_x     = 0;
    m_y     = 0;
    m_fill  = 0;
    m_word  = '0;
    exp_ovf = 1'b0;
  endtask

  // A finished word is either queued for the framebuffer or lost to a full queue.
  task automatic emit();
    if (exp_q.size() >= 2) exp_ovf = 1'b1;
    else exp_q.push_back({AW'(m_word_addr), m_word});
    m_word = '0;
    m_fill = 0;
  endtask

  task automatic model_event(input bit c, input bit h, input bit v, input logic [PB-1:0] p);
    if (!m_cap) begin
      if (v && enable) begin
        m_cap  = 1'b1;
        m_x    = 0;
        m_y    = 0;
        m_fill = 0;
        m_word = '0;
      end
      return;
    end
    if (c && m_x < H && m_y < V) begin
      m_word_addr = m_back * FW + m_y * WPL + m_x / PK;
      m_word[(m_x % PK) * PB +: PB] = p;
      m_x++;
      m_fill++;
      if (m_fill == PK) emit();
    end
    if (v) begin
      if (m_fill > 0) emit();
      if (m_x > 0 || m_y > 0) exp_frames++;
      m_front = m_back;
      m_back  = 1 - m_back;
      m_x     = 0;
      m_y     = 0;
      if (!enable) m_cap = 1'b0;
    end else if (h) begin
      if (m_fill > 0) emit();
      m_x = 0;
      if (m_y < V) m_y++;
    end
  endtask

  // One strobe cycle followed by one idle cycle so every strobe is a fresh rising edge.
  task automatic apply_stimulus(input bit c, input bit h, input bit v, input bit vld,
                                input logic [PB-1:0] p);
    cpl   = c;
    hs    = h;
    vs    = v;
    valid = vld;
    pixel = p;
    model_event(c && vld, h, v, p);
    step();
    cpl = 1'b0;
    hs  = 1'b0;
    vs  = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || wr_valid) && n < 200) begin
      step();
      n++;
    end
    repeat (6) step();
    check_output(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_log(input string name, input int idx, input int a, input logic [7:0] d);
    logic [EW-1:0] want;
    want = {AW'(a), d};
    if (idx < acc_log.size()) check_output(name, 32'(acc_log[idx]), 32'(want));
    else check_output(name, 32'(acc_log.size()), 32'(idx + 1));
  endtask

  // Every cycle the port carries a write, it must be the oldest owed word.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) dut_frames++;
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          check_output("write_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          check_output("wr_addr", 32'(wr_addr), 32'(exp_q[0][EW-1:PK*PB]));
          check_output("wr_data", 32'(wr_data), 32'(exp_q[0][PK*PB-1:0]));
          if (wr_ready) begin
            acc_log.push_back({wr_addr, wr_data});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: run exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    cpl      = 1'b0;
    hs       = 1'b0;
    vs       = 1'b0;
    valid    = 1'b0;
    pixel    = '0;
    wr_ready = 1'b1;
    model_reset();
    repeat (3) step();
    check_output("reset_wr_valid", 32'(wr_valid), 32'd0);
    check_output("reset_wr_addr", 32'(wr_addr), 32'd0);
    check_output("reset_wr_data", 32'(wr_data), 32'd0);
    check_output("reset_front_buf", 32'(front_buf), 32'd0);
    check_output("reset_frame_done", 32'(frame_done), 32'd0);
    check_output("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    // Full frame of pixel = x mod 4 into buffer 0.
    enable = 1'b1;
    apply_stimulus(0, 0, 1, 0, 2'd0);
    for (int ly = 0; ly < V; ly++) begin
      for (int lx = 0; lx < H; lx++) apply_stimulus(1, 0, 0, 1, 2'(lx));
      apply_stimulus(0, 1, 0, 0, 2'd0);
    end
    apply_stimulus(0, 0, 1, 0, 2'd0);
    wait_drain("frame1_drain");
    check_output("frame1_writes", 32'(acc_log.size()), 32'd5760);
    check_log("frame1_first", 0, 0, 8'hE4);
    check_log("frame1_last", 5759, 5759, 8'hE4);
    check_output("frame1_done_count", 32'(dut_frames), 32'd1);
    check_output("frame1_done_model", 32'(dut_frames), 32'(exp_frames));
    check_output("frame1_front_buf", 32'(front_buf), 32'd0);

    // Short line in buffer 1, with an invalid pixel strobe in the middle.
    apply_stimulus(1, 0, 0, 1, 2'd3);
    apply_stimulus(1, 0, 0, 1, 2'd3);
    apply_stimulus(1, 0, 0, 1, 2'd3);
    apply_stimulus(1, 0, 0, 1, 2'd3);
    apply_stimulus(1, 0, 0, 0, 2'd2);
    apply_stimulus(1, 0, 0, 1, 2'd1);
    apply_stimulus(1, 0, 0, 1, 2'd1);
    apply_stimulus(0, 1, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 1, 2'd2);
    wait_drain("short_line_drain");
    check_log("short_full_word", 5760, 5760, 8'hFF);
    check_log("short_partial_word", 5761, 5761, 8'h05);
    check_log("short_next_line", 5762, 5800, 8'hAA);
    apply_stimulus(0, 0, 1, 0, 2'd0);
    wait_drain("frame2_drain");
    check_output("frame2_done_count", 32'(dut_frames), 32'd2);
    check_output("frame2_front_buf", 32'(front_buf), 32'd1);

    // Twelve words against a stalled port: two held, the rest dropped.
    wr_ready = 1'b0;
    for (int i = 0; i < 48; i++) apply_stimulus(1, 0, 0, 1, 2'(i / 4));
    repeat (8) step();
    check_output("stall_wr_valid", 32'(wr_valid), 32'd1);
    check_output("stall_wr_addr", 32'(wr_addr), 32'd0);
    check_output("stall_overflow", 32'(overflow), 32'd1);
    check_output("stall_overflow_model", 32'(overflow), 32'(exp_ovf));
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 1, 2'd3);
    wait_drain("stall_drain");
    check_log("stall_held0", 5763, 0, 8'h00);
    check_log("stall_held1", 5764, 1, 8'h55);
    check_log("stall_resume", 5765, 12, 8'hFF);

    // Pixel, hs and vs rising together: pixel lands at old x, frame ends once.
    apply_stimulus(1, 1, 1, 1, 2'd2);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 1, 2'd1);
    wait_drain("coincident_drain");
    check_log("coincident_flush", 5766, 13, 8'h02);
    check_log("coincident_next_frame", 5767, FW, 8'h55);
    check_output("coincident_done_count", 32'(dut_frames), 32'd3);
    check_output("coincident_front_buf", 32'(front_buf), 32'd0);

    // Reset in the middle of a partial word.
    apply_stimulus(1, 0, 0, 1, 2'd3);
    apply_stimulus(1, 0, 0, 1, 2'd3);
    rst = 1'b1;
    step();
    check_output("midreset_wr_valid", 32'(wr_valid), 32'd0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 1, 2'd2);
    repeat (10) step();
    check_output("midreset_no_write", 32'(acc_log.size()), 32'd5768);
    apply_stimulus(0, 0, 1, 0, 2'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 1, 2'd3);
    wait_drain("midreset_drain");
    check_log("midreset_resume", 5768, 0, 8'hFF);
    check_output("midreset_front_buf", 32'(front_buf), 32'd0);
    check_output("midreset_overflow", 32'(overflow), 32'(exp_ovf));
    check_output("final_done_model", 32'(dut_frames), 32'(exp_frames));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
